logic_pipe: RTL and testbench
=============================

LOGIC_PIPE -- requirements
Module: logic_pipe

Interface
REQ-001 Parameter W, default 8: data width of every operand and result bus, legal range 1..64.
REQ-002 Parameter CNT_W, default 16: width of the completed-transaction counter.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous reset, active-high; sampled only on the rising edge of clk.
REQ-005 in_valid  input  1  the A/B/C operands are valid this cycle.
REQ-006 in_ready  output  1  the block accepts the operands this cycle.
REQ-007 A  input  W  operand A.
REQ-008 B  input  W  operand B.
REQ-009 C  input  W  operand C.
REQ-010 out_valid  output  1  D/F hold a valid result.
REQ-011 out_ready  input  1  the downstream consumer accepts the result this cycle.
REQ-012 D  output  W  result D.
REQ-013 F  output  W  result F.
REQ-014 count  output  CNT_W  number of results delivered since reset.

Function
REQ-015 All operations are bitwise across W bits; there is no arithmetic carry.
REQ-016 Stage 1 registers the following from one accepted transaction:
  - a1 = A
  - d1 = A ^ B
  - y1 = ~(A ^ B) & A
  - f1 = ~A & C
REQ-017 Stage 2 registers D = a1 ^ d1 and F = y1 | f1; every term entering a result comes from the same transaction (no mixing of operands across cycles).
REQ-018 A transfer occurs on the input when in_valid & in_ready, and on the output when out_valid & out_ready.
REQ-019 Let s1_valid be the stage-1 occupancy flag; s2_ready = ~out_valid | out_ready and in_ready = ~s1_valid | s2_ready, both combinational.
REQ-020 Stage 1 loads on an input transfer; s1_valid is set by an input transfer and cleared when stage 1 moves to stage 2 with no new input.
REQ-021 Stage 2 loads from stage 1 when s1_valid & s2_ready; out_valid is set by that load and cleared by an output transfer with no new load.
REQ-022 Latency: with out_ready held high, a result appears on D/F with out_valid high exactly 2 cycles after the input transfer.
REQ-023 Throughput is one transaction per cycle while out_ready stays high; no bubble is inserted.
REQ-024 Backpressure: while out_valid & ~out_ready, D, F and out_valid hold stable, and stage 1 holds its contents.
REQ-025 With both stages full and out_ready low, in_ready is low; transactions are never dropped or duplicated.
REQ-026 When the output drains and a new input arrives in the same cycle, both transfers complete in that cycle.
REQ-027 count increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0 with no flag.
REQ-028 A, B and C are don't-care when in_valid is low; the registers holding data do not load in that case.

Reset
REQ-029 While rst is high at a clock edge: s1_valid=0, out_valid=0, D=0, F=0, count=0, and stage-1 data registers are cleared to 0.
REQ-030 During reset, in_ready evaluates to 1 combinationally; no transfer taken in a reset cycle has any effect.
REQ-031 Reset asserted mid-stream discards all in-flight transactions; the first input after rst deasserts completes with the REQ-022 latency.

Verification
REQ-032 W=8, out_ready=1; input A=0xF0, B=0xCC, C=0xAA -> 2 cycles later out_valid=1, D=0xCC, F=0xCA, count=1.
REQ-033 Back-to-back: 10 consecutive random inputs with out_ready=1 -> 10 results in order on consecutive cycles matching the REQ-016/017 model, with in_ready constantly 1.
REQ-034 Stall: two transfers, then out_ready=0 for 5 cycles -> in_ready=0 after both stages fill, D/F stable, no loss; after out_ready=1 both results drain in order.
REQ-035 Random in_valid/out_ready (50% each, 2000 cycles) against a scoreboard -> zero mismatches, and count equals the number of output transfers mod 2^CNT_W.
REQ-036 rst pulsed for 1 cycle with both stages full -> next cycle out_valid=0, count=0, D=F=0; a subsequent A=0x00, B=0xFF, C=0x0F yields D=0xFF, F=0x0F.
REQ-037 CNT_W=4: deliver 17 results -> count reads 0x1 after the 17th transfer.

Source files
------------

// File: rtl/logic_pipe.sv
// logic_pipe: two-stage bitwise pipeline with valid/ready flow control.
// Stage 1 captures A, A^B, ~(A^B)&A and ~A&C from one accepted input;
// stage 2 combines them into D = a1 ^ d1 and F = y1 | f1.
// A counter reports the number of results delivered since reset.
//
// Handshake: a transfer happens on a port in every cycle where its valid
// and ready are both high at the rising edge of clk. A producer holds
// valid and its payload stable until it sees ready. Ready may depend
// combinationally on the downstream ready, but never on the valid of the
// same port.
module logic_pipe #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    input  logic [W-1:0]     C,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     D,
    output logic [W-1:0]     F,
    output logic [CNT_W-1:0] count
);

    // Stage-1 occupancy and the four intermediate terms of one transaction.
    logic         s1_valid;
    logic [W-1:0] a1;
    logic [W-1:0] d1;
    logic [W-1:0] y1;
    logic [W-1:0] f1;

    // Handshake terms shared by both stages.
    logic s2_ready;
    logic in_xfer;
    logic out_xfer;
    logic s1_move;

    // Flow control: stage 2 can take data when it is empty or draining this
    // cycle; stage 1 can take data when it is empty or moving forward.
    // The rst term forces in_ready high while reset is applied; any transfer
    // seen in such a cycle is discarded by the reset branches below.
    always_comb begin
        s2_ready = ~out_valid | out_ready;
        in_ready = rst | ~s1_valid | s2_ready;
        in_xfer  = in_valid & in_ready;
        out_xfer = out_valid & out_ready;
        s1_move  = s1_valid & s2_ready;
    end

    // Stage 1: capture the intermediate terms of an accepted input.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            a1       <= '0;
            d1       <= '0;
            y1       <= '0;
            f1       <= '0;
        end else begin
            if (in_xfer) begin
                a1 <= A;
                d1 <= A ^ B;
                y1 <= ~(A ^ B) & A;
                f1 <= ~A & C;
            end
            if (in_xfer) begin
                s1_valid <= 1'b1;
            end else if (s1_move) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2: combine the stage-1 terms; hold while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            D         <= '0;
            F         <= '0;
        end else begin
            if (s1_move) begin
                D         <= a1 ^ d1;
                F         <= y1 | f1;
                out_valid <= 1'b1;
            end else if (out_xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Delivered-result counter; wraps silently at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (out_xfer) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_logic_pipe.sv
// tb_logic_pipe: directed bench for logic_pipe (W=8, CNT_W=16) with a
// second instance (CNT_W=4) sharing the same stimulus for counter wrap.
// Expected results come from the reduced form D = B, F = (A & B) | (~A & C).
module tb_logic_pipe;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] C = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] D;
  logic [W-1:0] F;
  logic [15:0]  count;

  logic         in_ready4;
  logic         out_valid4;
  logic [W-1:0] d4;
  logic [W-1:0] f4;
  logic [3:0]   count4;

  logic_pipe #(.W(W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .C(C), .out_valid(out_valid), .out_ready(out_ready),
    .D(D), .F(F), .count(count)
  );

  logic_pipe #(.W(W), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .A(A), .B(B), .C(C), .out_valid(out_valid4), .out_ready(out_ready),
    .D(d4), .F(f4), .count(count4)
  );

  // ---------------- scoreboard state ----------------
  logic [2*W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int out_xfers = 0;
  int cyc = 0;
  logic last_in_ready = 1'b0;
  logic last_out_xfer = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, b, c);
    return {b, (a & b) | (~a & c)};
  endfunction

  // ---------------- driver ----------------
  // Drive one cycle, record both transfers in the scoreboard, then step
  // to 1 time unit after the next rising edge.
  task automatic cycle(input logic iv, input logic [W-1:0] a, b, c, input logic ordy);
    logic [2*W-1:0] e;
    in_valid = iv; A = a; B = b; C = c; out_ready = ordy;
    #1;
    last_in_ready = in_ready;
    last_out_xfer = out_valid & ordy;
    if (iv && in_ready) exp_q.push_back(model(a, b, c));
    if (out_valid && ordy) begin
      check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_D", 64'(D), 64'(e[2*W-1:W]));
        check("sb_F", 64'(F), 64'(e[W-1:0]));
      end
      out_xfers++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    A = 8'h11; B = 8'h22; C = 8'h33;
    out_ready = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    out_xfers = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int first_x;
    int last_x;
    int ir_low;
    logic [W-1:0] ra, rb, rc;

    @(posedge clk);
    #1;
    do_reset();
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_D", 64'(D), 64'd0);
    check("reset_F", 64'(F), 64'd0);
    check("reset_count", 64'(count), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);

    // Single transaction latency and values.
    cycle(1'b1, 8'hF0, 8'hCC, 8'hAA, 1'b1);
    check("lat_not_early", 64'(out_valid), 64'd0);
    cycle(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    check("lat_out_valid", 64'(out_valid), 64'd1);
    check("lat_D", 64'(D), 64'hCC);
    check("lat_F", 64'(F), 64'hCA);
    cycle(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    check("lat_count", 64'(count), 64'd1);
    check("lat_drained", 64'(out_valid), 64'd0);

    // Back-to-back: 10 inputs, results on consecutive cycles.
    first_x = -1; last_x = -1; ir_low = 0;
    out_xfers = 0;
    for (int i = 0; i < 12; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 8'($urandom_range(0, 255));
      cycle(i < 10, ra, rb, rc, 1'b1);
      if (i < 10 && !last_in_ready) ir_low++;
      if (last_out_xfer) begin
        if (first_x < 0) first_x = i;
        last_x = i;
      end
    end
    check("b2b_in_ready_low", 64'(ir_low), 64'd0);
    check("b2b_results", 64'(out_xfers), 64'd10);
    check("b2b_first", 64'(first_x), 64'd2);
    check("b2b_span", 64'(last_x - first_x), 64'd9);
    check("b2b_count", 64'(count), 64'd11);

    // Stall with both stages full; offered inputs must be refused.
    cycle(1'b1, 8'h3C, 8'h5A, 8'hFF, 1'b0);
    cycle(1'b1, 8'h81, 8'h7E, 8'h42, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 8'($urandom_range(0, 255)), 8'h99, 8'h99, 1'b0);
      check("stall_in_ready", 64'(last_in_ready), 64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_D", 64'(D), 64'h5A);
      check("stall_F", 64'(F), 64'hDB);
    end
    cycle(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    check("drain1_D", 64'(D), 64'h7E);
    check("drain1_F", 64'(F), 64'h42);
    cycle(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    check("stall_q_empty", 64'(exp_q.size()), 64'd0);
    check("stall_count", 64'(count), 64'd13);

    // Random valid/ready traffic against the scoreboard.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    check("rand_q_empty", 64'(exp_q.size()), 64'd0);
    check("rand_count", 64'(count), 64'(out_xfers % 65536));
    check("rand_idle", 64'(out_valid), 64'd0);

    // Reset with both stages full.
    cycle(1'b1, 8'h12, 8'h34, 8'h56, 1'b0);
    cycle(1'b1, 8'h9A, 8'hBC, 8'hDE, 1'b0);
    check("full_in_ready", 64'(in_ready), 64'd0);
    do_reset();
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_D", 64'(D), 64'd0);
    check("midrst_F", 64'(F), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    cycle(1'b1, 8'h00, 8'hFF, 8'h0F, 1'b1);
    cycle(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    check("postrst_out_valid", 64'(out_valid), 64'd1);
    check("postrst_D", 64'(D), 64'hFF);
    check("postrst_F", 64'(F), 64'h0F);
    cycle(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    check("postrst_q_empty", 64'(exp_q.size()), 64'd0);

    // Counter wrap on the CNT_W=4 instance.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)), 1'b1);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    check("wrap_count16", 64'(count), 64'd17);
    check("wrap_count4", 64'(count4), 64'd1);
    check("wrap_out_valid4", 64'(out_valid4), 64'd0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
